// File: rtl/knights_pkg.sv
// Shared constants and types for the KnightsTour remote command link.
package knights_pkg;

   localparam logic [7:0] POS_ACK  = 8'hA5;
   localparam logic [7:0] MOVE_ACK = 8'h5A;

   localparam int DEFAULT_BAUD_CYCLES    = 2604;
   localparam int DEFAULT_BYTE_TO_CYCLES = 2000000;

   typedef enum logic {IDLE, WAIT_LO} rx_state_t;

   // Bit counters stop at 10 so they can never wrap into a valid bit index.
   function automatic logic [3:0] bit_inc(input logic [3:0] b);
      return (b >= 4'd10) ? 4'd10 : b + 4'd1;
   endfunction

endpackage

// File: rtl/uart_trx.sv
// 8N1 byte transceiver: mid-bit sampling receiver and a shift-register transmitter.
module uart_trx
   import knights_pkg::*;
#(
   parameter int BAUD_CYCLES = DEFAULT_BAUD_CYCLES
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       RX,
   output logic [7:0] rx_data,
   output logic       rx_rdy,
   output logic       rx_frm_err,
   output logic       rx_busy,
   input  logic [7:0] tx_data,
   input  logic       trmt,
   output logic       TX,
   output logic       tx_done
);

   localparam int BW = $clog2(BAUD_CYCLES * 3 / 2 + 1);
   localparam logic [BW-1:0] BAUD_RELOAD  = BW'(BAUD_CYCLES - 1);
   localparam logic [BW-1:0] FIRST_RELOAD = BW'(BAUD_CYCLES * 3 / 2 - 1);

   logic          rx_meta_reg, rx_sync_reg, rx_prev_reg;
   logic          rx_busy_reg, rx_rdy_reg, rx_frm_err_reg;
   logic [BW-1:0] rx_baud_reg;
   logic [3:0]    rx_bit_reg;
   logic [7:0]    rx_shift_reg;

   logic [9:0]    tx_shift_reg;
   logic          tx_busy_reg, tx_done_reg;
   logic [BW-1:0] tx_baud_reg;
   logic [3:0]    tx_bit_reg;

   // Receiver: nine mid-bit samples (8 data + stop), the first 1.5 bits past the start edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_reg    <= 1'b1;
         rx_sync_reg    <= 1'b1;
         rx_prev_reg    <= 1'b1;
         rx_busy_reg    <= 1'b0;
         rx_rdy_reg     <= 1'b0;
         rx_frm_err_reg <= 1'b0;
         rx_baud_reg    <= '0;
         rx_bit_reg     <= '0;
         rx_shift_reg   <= '0;
      end else begin
         rx_meta_reg    <= RX;
         rx_sync_reg    <= rx_meta_reg;
         rx_prev_reg    <= rx_sync_reg;
         rx_rdy_reg     <= 1'b0;
         rx_frm_err_reg <= 1'b0;
         if (!rx_busy_reg) begin
            if (rx_prev_reg && !rx_sync_reg) begin
               rx_busy_reg <= 1'b1;
               rx_baud_reg <= FIRST_RELOAD;
               rx_bit_reg  <= '0;
            end
         end else if (rx_baud_reg != '0) begin
            rx_baud_reg <= rx_baud_reg - 1'b1;
         end else begin
            rx_baud_reg <= BAUD_RELOAD;
            rx_bit_reg  <= bit_inc(rx_bit_reg);
            if (rx_bit_reg < 4'd8) begin
               rx_shift_reg <= {rx_sync_reg, rx_shift_reg[7:1]};
            end else begin
               rx_busy_reg <= 1'b0;
               if (rx_sync_reg) rx_rdy_reg     <= 1'b1;
               else             rx_frm_err_reg <= 1'b1;
            end
         end
      end
   end

   assign rx_data    = rx_shift_reg;
   assign rx_rdy     = rx_rdy_reg;
   assign rx_frm_err = rx_frm_err_reg;
   assign rx_busy    = rx_busy_reg;

   // Transmitter: the shifter resets to all ones so TX idles high straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_shift_reg <= '1;
         tx_busy_reg  <= 1'b0;
         tx_done_reg  <= 1'b0;
         tx_baud_reg  <= '0;
         tx_bit_reg   <= '0;
      end else if (!tx_busy_reg) begin
         if (trmt) begin
            tx_shift_reg <= {1'b1, tx_data, 1'b0};
            tx_busy_reg  <= 1'b1;
            tx_done_reg  <= 1'b0;
            tx_baud_reg  <= BAUD_RELOAD;
            tx_bit_reg   <= '0;
         end
      end else if (tx_baud_reg != '0) begin
         tx_baud_reg <= tx_baud_reg - 1'b1;
      end else if (tx_bit_reg == 4'd9) begin
         tx_busy_reg <= 1'b0;
         tx_done_reg <= 1'b1;
         tx_bit_reg  <= bit_inc(tx_bit_reg);
      end else begin
         tx_shift_reg <= {1'b1, tx_shift_reg[9:1]};
         tx_baud_reg  <= BAUD_RELOAD;
         tx_bit_reg   <= bit_inc(tx_bit_reg);
      end
   end

   assign TX      = tx_shift_reg[0];
   assign tx_done = tx_done_reg;

endmodule

// File: rtl/uart_cmd_wrapper.sv
// Assembles two received bytes (high first) into a 16-bit command and sends response bytes.
module uart_cmd_wrapper
   import knights_pkg::*;
#(
   parameter int BAUD_CYCLES    = DEFAULT_BAUD_CYCLES,
   parameter int BYTE_TO_CYCLES = DEFAULT_BYTE_TO_CYCLES
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        RX,
   output logic        TX,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic [7:0]  resp,
   input  logic        trmt,
   output logic        tx_done
);

   localparam int TW = $clog2(BYTE_TO_CYCLES + 1);
   localparam logic [TW-1:0] TO_LIMIT = TW'(BYTE_TO_CYCLES);

   logic [7:0]  rx_data;
   logic        rx_rdy, rx_frm_err, rx_busy;

   rx_state_t   state_reg, state_next;
   logic        latch_hi, latch_lo, timer_run;
   logic [TW-1:0] timer_reg;
   logic [15:0] cmd_reg;
   logic        cmd_rdy_reg;

   uart_trx #(
      .BAUD_CYCLES(BAUD_CYCLES)
   ) u_trx (
      .clk       (clk),
      .rst_n     (rst_n),
      .RX        (RX),
      .rx_data   (rx_data),
      .rx_rdy    (rx_rdy),
      .rx_frm_err(rx_frm_err),
      .rx_busy   (rx_busy),
      .tx_data   (resp),
      .trmt      (trmt),
      .TX        (TX),
      .tx_done   (tx_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // The inter-byte timer only runs while the line is idle; a frame in flight pauses it.
   always_comb begin
      state_next = state_reg;
      latch_hi   = 1'b0;
      latch_lo   = 1'b0;
      timer_run  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (rx_rdy) begin
               latch_hi   = 1'b1;
               state_next = WAIT_LO;
            end
         end
         WAIT_LO: begin
            if (rx_rdy) begin
               latch_lo   = 1'b1;
               state_next = IDLE;
            end else if (rx_frm_err) begin
               state_next = IDLE;
            end else if (!rx_busy) begin
               if (timer_reg == TO_LIMIT) state_next = IDLE;
               else                       timer_run  = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer_reg   <= '0;
         cmd_reg     <= '0;
         cmd_rdy_reg <= 1'b0;
      end else begin
         if (state_reg == IDLE) timer_reg <= '0;
         else if (timer_run)    timer_reg <= timer_reg + 1'b1;

         if (latch_hi) cmd_reg[15:8] <= rx_data;
         if (latch_lo) cmd_reg[7:0]  <= rx_data;

         // A completing command beats a simultaneous acknowledge.
         if (latch_lo)                     cmd_rdy_reg <= 1'b1;
         else if (latch_hi || clr_cmd_rdy) cmd_rdy_reg <= 1'b0;
      end
   end

   assign cmd     = cmd_reg;
   assign cmd_rdy = cmd_rdy_reg;

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Scoreboard bench: stimulus queues expected commands/response bytes, monitors pop and compare.
module tb_uart_cmd_wrapper;

   localparam int B  = 16;
   localparam int TO = 400;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        RX;
   logic        TX;
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy;
   logic [7:0]  resp;
   logic        trmt;
   logic        tx_done;

   int checks = 0;
   int fails  = 0;
   int cycle_cnt = 0;
   int stop_mid_cycle = 0;

   logic [15:0] cmd_exp[$];
   logic [7:0]  tx_exp[$];

   always #5 clk = ~clk;
   always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

   uart_cmd_wrapper #(
      .BAUD_CYCLES   (B),
      .BYTE_TO_CYCLES(TO)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .RX         (RX),
      .TX         (TX),
      .cmd        (cmd),
      .cmd_rdy    (cmd_rdy),
      .clr_cmd_rdy(clr_cmd_rdy),
      .resp       (resp),
      .trmt       (trmt),
      .tx_done    (tx_done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   task automatic send_byte(input logic [7:0] d, input logic stop);
      @(negedge clk);
      RX = 1'b0;
      repeat (B) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         RX = d[i];
         repeat (B) @(negedge clk);
      end
      RX = stop;
      repeat (B / 2) @(negedge clk);
      stop_mid_cycle = cycle_cnt;
      repeat (B - B / 2 - 1) @(negedge clk);
      RX = 1'b1;
   endtask

   task automatic idle(input int n);
      RX = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic transmit(input logic [7:0] b);
      @(negedge clk);
      resp = b;
      trmt = 1'b1;
      tx_exp.push_back(b);
      @(negedge clk);
      trmt = 1'b0;
   endtask

   // Command monitor: every rising cmd_rdy must match the next queued command.
   logic rdy_prev = 1'b0;
   always @(negedge clk) begin
      if (rst_n && cmd_rdy && !rdy_prev) begin
         if (cmd_exp.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL cmd_unexpected: got %h expected none", cmd);
         end else begin
            check("cmd", cmd, cmd_exp.pop_front());
            check("cmd_rdy_latency_ok", ((cycle_cnt - stop_mid_cycle) <= B / 2 + 3), 1);
         end
      end
      rdy_prev <= cmd_rdy;
   end

   // TX monitor: decodes each frame at bit mid-points; frames cut by reset are discarded.
   logic [7:0] tx_bits;
   logic       tx_start, tx_stop, tx_ab;
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && TX == 1'b0) begin
            tx_ab = 1'b0;
            for (int k = 0; k < B / 2; k++) begin @(negedge clk); if (!rst_n) tx_ab = 1'b1; end
            tx_start = TX;
            for (int i = 0; i < 8; i++) begin
               for (int k = 0; k < B; k++) begin @(negedge clk); if (!rst_n) tx_ab = 1'b1; end
               tx_bits[i] = TX;
            end
            for (int k = 0; k < B; k++) begin @(negedge clk); if (!rst_n) tx_ab = 1'b1; end
            tx_stop = TX;
            if (tx_exp.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL tx_unexpected: got %h expected none", tx_bits);
            end else if (tx_ab) begin
               void'(tx_exp.pop_front());
            end else begin
               check("tx_byte", tx_bits, tx_exp.pop_front());
               check("tx_start_stop", {tx_start, tx_stop}, 2'b01);
            end
         end
      end
   end

   int n;
   initial begin
      rst_n = 1'b0;
      RX = 1'b1;
      trmt = 1'b0;
      clr_cmd_rdy = 1'b0;
      resp = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_TX", TX, 1);
      check("rst_cmd", cmd, 0);
      check("rst_cmd_rdy", cmd_rdy, 0);
      check("rst_tx_done", tx_done, 0);
      rst_n = 1'b1;
      idle(4);

      // Back-to-back bytes, then acknowledge
      cmd_exp.push_back(16'h6020);
      send_byte(8'h60, 1'b1);
      send_byte(8'h20, 1'b1);
      check("cmd_rdy_held", cmd_rdy, 1);
      @(negedge clk) clr_cmd_rdy = 1'b1;
      @(negedge clk) clr_cmd_rdy = 1'b0;
      check("clr_cmd_rdy", cmd_rdy, 0);
      check("cmd_stable", cmd, 16'h6020);

      // Inter-byte timeout resynchronises; a gap under the limit does not
      cmd_exp.push_back(16'h4005);
      send_byte(8'h2F, 1'b1);
      idle(TO + 10);
      send_byte(8'h40, 1'b1);
      send_byte(8'h05, 1'b1);
      cmd_exp.push_back(16'h1122);
      send_byte(8'h11, 1'b1);
      idle(300);
      send_byte(8'h22, 1'b1);

      // Framing error on a high byte discards it
      cmd_exp.push_back(16'h1234);
      send_byte(8'h31, 1'b0);
      idle(2 * B);
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);

      // Response transmission with a trmt during bit 4 that must be ignored
      @(negedge clk);
      resp = 8'hA5;
      trmt = 1'b1;
      tx_exp.push_back(8'hA5);
      @(negedge clk);
      trmt = 1'b0;
      check("tx_start_next_cycle", TX, 0);
      check("tx_done_cleared", tx_done, 0);
      n = 0;
      while (!tx_done && n < 12 * B) begin
         @(negedge clk);
         n++;
         if (n == 4 * B + 2) begin resp = 8'h3C; trmt = 1'b1; end
         else if (n == 4 * B + 3) begin trmt = 1'b0; resp = 8'hA5; end
      end
      check("tx_done_cycles", n, 10 * B);
      idle(2 * B);

      // Reset in the middle of a low byte and a response frame
      send_byte(8'h60, 1'b1);
      transmit(8'h00);
      fork
         send_byte(8'h20, 1'b1);
         begin
            repeat (4 * B) @(negedge clk);
            #2 rst_n = 1'b0;
            #1;
            check("midrst_TX", TX, 1);
            check("midrst_cmd_rdy", cmd_rdy, 0);
            check("midrst_cmd", cmd, 0);
            check("midrst_tx_done", tx_done, 0);
         end
      join
      @(negedge clk) rst_n = 1'b1;
      idle(12 * B);
      cmd_exp.push_back(16'h1022);
      send_byte(8'h10, 1'b1);
      send_byte(8'h22, 1'b1);

      // New high byte clears cmd_rdy; a set coinciding with clr_cmd_rdy wins
      check("pre_hi_cmd_rdy", cmd_rdy, 1);
      cmd_exp.push_back(16'h7E81);
      send_byte(8'h7E, 1'b1);
      check("hi_byte_clears_rdy", cmd_rdy, 0);
      fork
         send_byte(8'h81, 1'b1);
         begin
            clr_cmd_rdy = 1'b1;
            n = 0;
            while (!cmd_rdy && n < 12 * B) begin @(negedge clk); n++; end
            clr_cmd_rdy = 1'b0;
            check("set_wins_rise", cmd_rdy, 1);
         end
      join
      repeat (3) @(negedge clk);
      check("set_wins_held", cmd_rdy, 1);
      check("set_wins_cmd", cmd, 16'h7E81);

      // Both directions at once
      cmd_exp.push_back(16'hABCD);
      fork
         begin
            send_byte(8'hAB, 1'b1);
            send_byte(8'hCD, 1'b1);
         end
         begin
            repeat (B) @(negedge clk);
            transmit(8'h5A);
         end
      join

      n = 0;
      while ((cmd_exp.size() != 0 || tx_exp.size() != 0) && n < 20 * B) begin
         @(negedge clk);
         n++;
      end
      check("cmd_queue_drained", cmd_exp.size(), 0);
      check("tx_queue_drained", tx_exp.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
